// File: rtl/fixed_point_sum_pipe.sv
// Two-stage pipelined signed fixed-point add/subtract/accumulate with optional
// saturation, overflow flag and valid/ready handshaking on both sides.
module fixed_point_sum_pipe #(
   parameter  int INT_BITS  = 22,
   parameter  int FRAC_BITS = 16,
   parameter  int SAT       = 1,
   localparam int W         = 2*(INT_BITS+FRAC_BITS)+1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic signed [W-1:0] in_a,
   input  logic signed [W-1:0] in_b,
   input  logic        [1:0]   op,
   output logic                out_valid,
   input  logic                out_ready,
   output logic signed [W-1:0] out,
   output logic                ovf
);

   // Returns {overflow, result}; overflow is a disagreement of the two top bits.
   function automatic logic [W:0] sat_fn(input logic signed [W:0] s);
      logic         v;
      logic [W-1:0] r;
      v = s[W] ^ s[W-1];
      r = s[W-1:0];
      if ((SAT != 0) && v)
         r = s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      return {v, r};
   endfunction

   logic signed [W:0]   lhs_p0, rhs_p0, sum_p0;
   logic signed [W-1:0] res_p0;
   logic                ovf_p0;
   logic signed [W-1:0] acc;

   logic                vld_p1;
   logic signed [W-1:0] res_p1;
   logic                ovf_p1;

   logic                ld_p1, ld_p2, accept;

   assign ld_p2    = !out_valid || out_ready;
   assign ld_p1    = !vld_p1 || ld_p2;
   assign in_ready = !rst && ld_p1;
   assign accept   = in_valid && in_ready;

   // Stage 0: exact W+1-bit sum, then saturate or wrap
   always_comb begin
      lhs_p0 = '0;
      rhs_p0 = '0;
      case (op)
         2'b00: begin
            lhs_p0 = {in_a[W-1], in_a};
            rhs_p0 = {in_b[W-1], in_b};
         end
         2'b01: begin
            lhs_p0 = {in_a[W-1], in_a};
            rhs_p0 = -{in_b[W-1], in_b};
         end
         2'b10: begin
            lhs_p0 = {acc[W-1], acc};
            rhs_p0 = {in_a[W-1], in_a};
         end
         default: begin
            lhs_p0 = {in_a[W-1], in_a};
            rhs_p0 = '0;
         end
      endcase
      sum_p0           = lhs_p0 + rhs_p0;
      {ovf_p0, res_p0} = sat_fn(sum_p0);
   end

   // Stage 1 / stage 2 control, output register and accumulator
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1    <= 1'b0;
         out_valid <= 1'b0;
         out       <= '0;
         ovf       <= 1'b0;
         acc       <= '0;
      end else begin
         if (ld_p1)
            vld_p1 <= accept;
         if (ld_p2)
            out_valid <= vld_p1;
         if (ld_p2 && vld_p1) begin
            out <= res_p1;
            ovf <= ovf_p1;
         end
         if (accept && op[1])
            acc <= res_p0;
      end
   end

   // Stage 1 data: qualified by vld_p1, so it needs no reset
   always_ff @(posedge clk) begin
      if (accept) begin
         res_p1 <= res_p0;
         ovf_p1 <= ovf_p0;
      end
   end

endmodule
